// File: rtl/russian_pkg.sv
`default_nettype none
// ============================================================================
// russian_pkg : mirroring-mode encodings and PPU address-map constants
// Revision    : 1.0
// ============================================================================
package russian_pkg;

  typedef logic [2:0] mirror_t;

  localparam mirror_t MIR_HORZ = 3'd0;
  localparam mirror_t MIR_VERT = 3'd1;
  localparam mirror_t MIR_SGLA = 3'd2;
  localparam mirror_t MIR_SGLB = 3'd3;
  localparam mirror_t MIR_FOUR = 3'd4;

  localparam logic [13:0] NT_BASE  = 14'h2000;
  localparam logic [13:0] PAL_BASE = 14'h3F00;

endpackage
`default_nettype wire

// File: rtl/vram_array.sv
`default_nettype none
// ============================================================================
// vram_array : single-port synchronous RAM, one write port, registered read
// Revision   : 1.0
// ============================================================================
module vram_array #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only loads on an enabled read, so it holds the last data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/ppu_nametable_ctrl.sv
`default_nettype none
// ============================================================================
// ppu_nametable_ctrl : PPU address latch, nametable mirroring and VRAM access
// Revision           : 1.0
// ============================================================================
module ppu_nametable_ctrl
  import russian_pkg::*;
#(
  parameter int RAM_AW = 11,
  parameter int DATA_W = 8,
  parameter int PAD_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAD_W-1:0]  pad_in,
  input  logic              ale,
  input  logic              rdn,
  input  logic              wrn,
  input  logic [2:0]        mirror,
  output logic [DATA_W-1:0] pad_out,
  output logic              pad_oe,
  output logic [PAD_W-1:0]  addr_q,
  output logic              chr_sel,
  output logic              strobe_err
);

  // Four-screen needs a 4 KiB array; with 2 KiB it falls back to vertical.
  function automatic logic [RAM_AW-1:0] map_phys(input mirror_t mode,
                                                 input logic [11:0] a);
    logic [1:0] bank;
    case (mode)
      MIR_VERT: bank = {1'b0, a[10]};
      MIR_SGLA: bank = 2'd0;
      MIR_SGLB: bank = 2'd1;
      MIR_FOUR: bank = (RAM_AW >= 12) ? a[11:10] : {1'b0, a[10]};
      default:  bank = {1'b0, a[11]};
    endcase
    return RAM_AW'({bank, a[9:0]});
  endfunction

  logic              rd_arm;
  logic              wr_arm;
  logic              hit;
  logic              err;
  logic              rd_trig;
  logic              wr_trig;
  logic [RAM_AW-1:0] phys;

  assign chr_sel = ~addr_q[13];
  assign hit     = (addr_q[13] == NT_BASE[13]) && (addr_q[13:8] != PAL_BASE[13:8]);
  assign phys    = map_phys(mirror_t'(mirror), addr_q[11:0]);

  assign err     = (~rdn & ~wrn) | (ale & (~rdn | ~wrn));
  assign rd_trig = ~rdn & rd_arm & wrn & ~ale;
  assign wr_trig = ~wrn & wr_arm & rdn & ~ale;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      pad_oe     <= 1'b0;
      strobe_err <= 1'b0;
      rd_arm     <= 1'b0;
      wr_arm     <= 1'b0;
    end else begin
      if (ale) addr_q <= pad_in;

      if (err) begin
        strobe_err <= 1'b1;
        rd_arm     <= 1'b0;
        wr_arm     <= 1'b0;
      end else begin
        if (rdn)          rd_arm <= 1'b1;
        else if (rd_trig) rd_arm <= 1'b0;
        if (wrn)          wr_arm <= 1'b1;
        else if (wr_trig) wr_arm <= 1'b0;
      end

      if (rdn)                pad_oe <= 1'b0;
      else if (rd_trig & hit) pad_oe <= 1'b1;
    end
  end

  vram_array #(
    .AW (RAM_AW),
    .DW (DATA_W)
  ) u_vram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_trig & hit),
    .re    (rd_trig & hit),
    .addr  (phys),
    .wdata (pad_in[DATA_W-1:0]),
    .rdata (pad_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_ppu_nametable_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ppu_nametable_ctrl : directed bench, 2 KiB and 4 KiB instances in lockstep
// Revision              : 1.0
// ============================================================================
module tb_ppu_nametable_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] pad_in;
  logic        ale;
  logic        rdn;
  logic        wrn;
  logic [2:0]  mirror;

  logic [7:0]  pad_out_a, pad_out_b;
  logic        pad_oe_a,  pad_oe_b;
  logic [13:0] addr_q_a,  addr_q_b;
  logic        chr_sel_a, chr_sel_b;
  logic        err_a,     err_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ppu_nametable_ctrl #(.RAM_AW(11), .DATA_W(8), .PAD_W(14)) dut_a (
    .clk(clk), .rst(rst), .pad_in(pad_in), .ale(ale), .rdn(rdn), .wrn(wrn),
    .mirror(mirror), .pad_out(pad_out_a), .pad_oe(pad_oe_a), .addr_q(addr_q_a),
    .chr_sel(chr_sel_a), .strobe_err(err_a)
  );

  ppu_nametable_ctrl #(.RAM_AW(12), .DATA_W(8), .PAD_W(14)) dut_b (
    .clk(clk), .rst(rst), .pad_in(pad_in), .ale(ale), .rdn(rdn), .wrn(wrn),
    .mirror(mirror), .pad_out(pad_out_b), .pad_oe(pad_oe_b), .addr_q(addr_q_b),
    .chr_sel(chr_sel_b), .strobe_err(err_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch(input logic [13:0] a);
    pad_in = a;
    ale    = 1'b1;
    tick();
    ale    = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [7:0] d);
    latch(a);
    pad_in = {6'h00, d};
    wrn    = 1'b0;
    tick();
    wrn    = 1'b1;
    tick();
  endtask

  // Hit read on both instances: oe rises one edge after rdn falls, drops one after it rises.
  task automatic rd(input string tag, input logic [13:0] a,
                    input logic [7:0] exp_a, input logic [7:0] exp_b);
    latch(a);
    rdn = 1'b0;
    tick();
    chk({tag, "_oe_a"}, 16'(pad_oe_a), 16'h1);
    chk({tag, "_oe_b"}, 16'(pad_oe_b), 16'h1);
    chk({tag, "_data_a"}, 16'(pad_out_a), 16'(exp_a));
    chk({tag, "_data_b"}, 16'(pad_out_b), 16'(exp_b));
    rdn = 1'b1;
    tick();
    chk({tag, "_oe_off_a"}, 16'(pad_oe_a), 16'h0);
    chk({tag, "_hold_a"}, 16'(pad_out_a), 16'(exp_a));
  endtask

  task automatic rd_miss(input string tag, input logic [13:0] a);
    latch(a);
    rdn = 1'b0;
    tick();
    chk({tag, "_oe_a"}, 16'(pad_oe_a), 16'h0);
    chk({tag, "_oe_b"}, 16'(pad_oe_b), 16'h0);
    rdn = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; pad_in = '0; ale = 1'b0; rdn = 1'b1; wrn = 1'b1; mirror = 3'd1;
    #2;
    chk("rst_addr_q",  16'(addr_q_a),  16'h0000);
    chk("rst_pad_out", 16'(pad_out_a), 16'h0000);
    chk("rst_pad_oe",  16'(pad_oe_a),  16'h0);
    chk("rst_err",     16'(err_a),     16'h0);
    chk("rst_chr_sel", 16'(chr_sel_a), 16'h1);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Vertical preloads and alias check
    wr(14'h2400, 8'h00);
    wr(14'h2710, 8'h77);
    wr(14'h2005, 8'hA5);
    wr(14'h2805, 8'h3C);
    latch(14'h2005);
    rdn = 1'b0;
    #1;
    chk("vert_oe_early", 16'(pad_oe_a), 16'h0);
    rdn = 1'b1;
    tick();
    rd("vert_alias", 14'h2005, 8'h3C, 8'h3C);

    // Horizontal
    mirror = 3'd0;
    wr(14'h2400, 8'h11);
    rd("horz_same", 14'h2000, 8'h11, 8'h11);
    rd("horz_other", 14'h2800, 8'h00, 8'h00);

    // Four-screen: distinct on 4 KiB, vertical aliasing on 2 KiB
    mirror = 3'd4;
    wr(14'h2000, 8'h01);
    wr(14'h2400, 8'h02);
    wr(14'h2800, 8'h03);
    wr(14'h2C00, 8'h04);
    rd("four_2000", 14'h2000, 8'h03, 8'h01);
    rd("four_2400", 14'h2400, 8'h04, 8'h02);
    rd("four_2800", 14'h2800, 8'h03, 8'h03);
    rd("four_2C00", 14'h2C00, 8'h04, 8'h04);

    // Long write pulse: only the first-sampled data lands
    mirror = 3'd1;
    latch(14'h2010);
    pad_in = 14'h0050;
    wrn    = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      pad_in = 14'(8'h50 + i);
    end
    wrn = 1'b1;
    tick();
    rd("long_wr", 14'h2010, 8'h50, 8'h50);

    // Pattern and palette space
    latch(14'h1234);
    chk("pat_chr_sel", 16'(chr_sel_a), 16'h1);
    rd_miss("pat_rd", 14'h1234);
    latch(14'h3F10);
    chk("pal_chr_sel", 16'(chr_sel_a), 16'h0);
    rd_miss("pal_rd", 14'h3F10);
    wr(14'h3F10, 8'hEE);
    rd("pal_nowrite", 14'h2710, 8'h77, 8'h77);

    // Both strobes low together
    latch(14'h2005);
    pad_in = 14'h0099;
    rdn = 1'b0; wrn = 1'b0;
    tick();
    chk("err_set_a", 16'(err_a), 16'h1);
    chk("err_set_b", 16'(err_b), 16'h1);
    chk("err_no_oe", 16'(pad_oe_a), 16'h0);
    rdn = 1'b1; wrn = 1'b1;
    tick();
    rd("err_no_write", 14'h2005, 8'h3C, 8'h3C);
    chk("err_sticky", 16'(err_a), 16'h1);

    // Reset mid-read, then release with rdn held low
    latch(14'h2005);
    rdn = 1'b0;
    tick();
    chk("pre_rst_oe", 16'(pad_oe_a), 16'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_oe",  16'(pad_oe_a), 16'h0);
    chk("rst_async_err", 16'(err_a),    16'h0);
    chk("rst_async_out", 16'(pad_out_a), 16'h00);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_low_no_oe", 16'(pad_oe_a), 16'h0);
    end
    rdn = 1'b1;
    tick();
    rd("rel_rearmed", 14'h2005, 8'h3C, 8'h3C);
    chk("rel_no_err", 16'(err_a), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
